// File: rtl/sudoku_pkg.sv
// Shared board geometry and cell/unit types for the sudoku datapath.
// Used by board_update, board_validator and the address generator.
package sudoku_pkg;
  localparam int GRID_N = 9;

  typedef logic [3:0] cell_t;
  localparam cell_t CELL_EMPTY = 4'd0;

  typedef cell_t [GRID_N-1:0][GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    UNIT_ROW = 2'd0,
    UNIT_COL = 2'd1,
    UNIT_BOX = 2'd2
  } unit_kind_t;
endpackage

// File: rtl/cell_addr_gen.sv
// Combinational map from (unit kind, unit index, cell index) to grid (row, col).
// Boxes are numbered left-to-right, top-to-bottom; cells inside a box likewise.
module cell_addr_gen
  import sudoku_pkg::*;
(
  input  unit_kind_t i_kind,
  input  logic [3:0] i_unit,
  input  logic [3:0] i_cell,
  output logic [3:0] o_row,
  output logic [3:0] o_col
);
  logic [3:0] w_unit_div;
  logic [3:0] w_unit_mod;
  logic [3:0] w_cell_div;
  logic [3:0] w_cell_mod;

  assign w_unit_div = i_unit / 4'd3;
  assign w_unit_mod = i_unit % 4'd3;
  assign w_cell_div = i_cell / 4'd3;
  assign w_cell_mod = i_cell % 4'd3;

  always_comb begin
    o_row = i_unit;
    o_col = i_cell;
    case (i_kind)
      UNIT_COL: begin
        o_row = i_cell;
        o_col = i_unit;
      end
      UNIT_BOX: begin
        o_row = 4'd3 * w_unit_div + w_cell_div;
        o_col = 4'd3 * w_unit_mod + w_cell_mod;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/board_validator.sv
// Snapshots the board on start and scans 27 units one cell per clock (244-cycle start-to-done).
// Reports the first conflicting unit, the empty-cell count and a solved flag; start is ignored while busy.
module board_validator
  import sudoku_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  grid_t      display_grid,
  output logic       busy,
  output logic       done,
  output logic       solved,
  output logic       conflict,
  output logic [1:0] conflict_kind,
  output logic [3:0] conflict_index,
  output logic [6:0] empty_count
);
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t     r_state;
  grid_t      r_snap;
  unit_kind_t r_kind;
  logic [3:0] r_unit;
  logic [3:0] r_cell;
  logic [8:0] r_seen;
  logic [6:0] r_empty_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_solved;
  logic       r_conflict;
  logic [1:0] r_conflict_kind;
  logic [3:0] r_conflict_index;
  logic [6:0] r_empty_count;

  logic [3:0] w_row;
  logic [3:0] w_col;
  cell_t      w_val;
  logic [8:0] w_digit;
  logic       w_bad;

  cell_addr_gen u_addr (
    .i_kind (r_kind),
    .i_unit (r_unit),
    .i_cell (r_cell),
    .o_row  (w_row),
    .o_col  (w_col)
  );

  assign w_val = r_snap[w_row][w_col];

  // One-hot digit mask; empty and illegal values contribute nothing to the seen set.
  always_comb begin
    w_digit = '0;
    if (w_val != CELL_EMPTY && w_val <= cell_t'(GRID_N))
      w_digit = 9'd1 << (w_val - 4'd1);
  end

  assign w_bad = (w_val > cell_t'(GRID_N)) || ((r_seen & w_digit) != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_snap           <= '0;
      r_kind           <= UNIT_ROW;
      r_unit           <= '0;
      r_cell           <= '0;
      r_seen           <= '0;
      r_empty_cnt      <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_solved         <= 1'b0;
      r_conflict       <= 1'b0;
      r_conflict_kind  <= '0;
      r_conflict_index <= '0;
      r_empty_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state          <= ST_SCAN;
            r_busy           <= 1'b1;
            r_snap           <= display_grid;
            r_kind           <= UNIT_ROW;
            r_unit           <= '0;
            r_cell           <= '0;
            r_seen           <= '0;
            r_empty_cnt      <= '0;
            r_solved         <= 1'b0;
            r_conflict       <= 1'b0;
            r_conflict_kind  <= '0;
            r_conflict_index <= '0;
            r_empty_count    <= '0;
          end
        end
        ST_SCAN: begin
          // Every cell appears in exactly one row, so only row passes count empties.
          if (w_val == CELL_EMPTY && r_kind == UNIT_ROW)
            r_empty_cnt <= r_empty_cnt + 7'd1;
          if (w_bad && !r_conflict) begin
            r_conflict       <= 1'b1;
            r_conflict_kind  <= r_kind;
            r_conflict_index <= r_unit;
          end
          if (r_cell == 4'd8) begin
            r_cell <= '0;
            r_seen <= '0;
            if (r_unit == 4'd8) begin
              r_unit <= '0;
              if (r_kind == UNIT_BOX)
                r_state <= ST_DONE;
              else
                r_kind <= unit_kind_t'(r_kind + 2'd1);
            end else begin
              r_unit <= r_unit + 4'd1;
            end
          end else begin
            r_cell <= r_cell + 4'd1;
            r_seen <= r_seen | w_digit;
          end
        end
        ST_DONE: begin
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
          r_empty_count <= r_empty_cnt;
          r_solved      <= !r_conflict && (r_empty_cnt == 7'd0);
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign solved         = r_solved;
  assign conflict       = r_conflict;
  assign conflict_kind  = r_conflict_kind;
  assign conflict_index = r_conflict_index;
  assign empty_count    = r_empty_count;
endmodule

// File: tb/tb_board_validator.sv
// Scoreboard bench for board_validator: expected results are queued at start acceptance
// and compared (including done timing) when done pulses.
module tb_board_validator;
  import sudoku_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  grid_t      display_grid;
  logic       busy;
  logic       done;
  logic       solved;
  logic       conflict;
  logic [1:0] conflict_kind;
  logic [3:0] conflict_index;
  logic [6:0] empty_count;

  board_validator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .display_grid   (display_grid),
    .busy           (busy),
    .done           (done),
    .solved         (solved),
    .conflict       (conflict),
    .conflict_kind  (conflict_kind),
    .conflict_index (conflict_index),
    .empty_count    (empty_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int solved;
    int conflict;
    int kind;
    int index;
    int empty;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: per unit, count each digit occurrence; any repeat or value above 9 flags the unit.
  function automatic exp_t model(input grid_t g, input int done_cyc);
    exp_t e;
    int   cnt[10];
    int   r, c;
    bit   bad;
    e = '{0, 0, 0, 0, 0, done_cyc};
    for (int k = 0; k < 3; k++) begin
      for (int u = 0; u < 9; u++) begin
        for (int d = 0; d < 10; d++) cnt[d] = 0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
          if (k == 0) begin r = u; c = i; end
          else if (k == 1) begin r = i; c = u; end
          else begin r = (u / 3) * 3 + i / 3; c = (u % 3) * 3 + i % 3; end
          if (g[r][c] > 4'd9) bad = 1;
          else if (g[r][c] != 4'd0) begin
            cnt[g[r][c]]++;
            if (cnt[g[r][c]] > 1) bad = 1;
          end
        end
        if (bad && e.conflict == 0) begin
          e.conflict = 1;
          e.kind = k;
          e.index = u;
        end
      end
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        if (g[i][j] == 4'd0) e.empty++;
    e.solved = (e.conflict == 0 && e.empty == 0) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_at_done", busy, 0);
        chk("solved", solved, e.solved);
        chk("conflict", conflict, e.conflict);
        chk("conflict_kind", conflict_kind, e.kind);
        chk("conflict_index", conflict_index, e.index);
        chk("empty_count", empty_count, e.empty);
      end
    end
  end

  task automatic start_scan(input grid_t g, output int k);
    @(negedge clock);
    display_grid = g;
    start = 1'b1;
    @(posedge clock);
    #1;
    k = cyc;
    start = 1'b0;
    sb.push_back(model(g, k + 244));
    chk("busy_on_accept", busy, 1);
  endtask

  task automatic wait_results();
    int budget;
    budget = 600;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    chk("done_timeout", sb.size(), 0);
    @(negedge clock);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  grid_t g_sol, g_zero, g_row, g_box, g_ill, g_junk;
  int    k;
  int    n_before;

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    g_zero = '0;
    display_grid = g_zero;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g_sol[r][c] = cell_t'(((r * 3 + r / 3 + c) % 9) + 1);
    g_row = g_zero; g_row[2][0] = 4'd7; g_row[2][5] = 4'd7;
    g_box = g_zero; g_box[0][0] = 4'd5; g_box[1][1] = 4'd5;
    g_ill = g_zero; g_ill[4][4] = 4'd10;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g_junk[r][c] = 4'd9;

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_solved", solved, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_kind", conflict_kind, 0);
    chk("rst_index", conflict_index, 0);
    chk("rst_empty", empty_count, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    start_scan(g_sol, k);
    wait_results();
    repeat (3) @(negedge clock);
    chk("solved_hold", solved, 1);

    start_scan(g_zero, k);
    wait_results();
    start_scan(g_row, k);
    wait_results();
    start_scan(g_box, k);
    wait_results();
    start_scan(g_ill, k);
    wait_results();

    start_scan(g_row, k);
    wait_until(k + 50);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_results();

    start_scan(g_sol, k);
    @(negedge clock);
    display_grid = g_junk;
    wait_results();

    // Continuous start: the second scan must be accepted exactly 245 edges after the first.
    @(negedge clock);
    display_grid = g_box;
    start = 1'b1;
    @(posedge clock);
    #1;
    k = cyc;
    sb.push_back(model(g_box, k + 244));
    sb.push_back(model(g_box, k + 245 + 244));
    while (cyc < k + 245) begin
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    chk("busy_reaccept", busy, 1);
    wait_results();

    start_scan(g_row, k);
    wait_until(k + 100);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_conflict", conflict, 0);
    chk("midrst_kind", conflict_kind, 0);
    chk("midrst_index", conflict_index, 0);
    sb.delete();
    n_before = n_done;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(negedge clock);
    chk("no_done_after_reset", n_done, n_before);

    start_scan(g_ill, k);
    wait_results();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
